// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer
//   Read-side consumer of the asynchronous FIFO. Pops words through the
//   FIFO read port and re-issues them as a valid/ready stream grouped into
//   packets of programmable length, with a last-beat marker on the final
//   word of every packet. A 2-entry output buffer decouples the pop strobe
//   from downstream ready while still sustaining one word per cycle.
//
// Ports
//   i_clk      read-domain clock
//   i_rst      synchronous active-high reset
//   i_en       1 = stream packets, 0 = stop at the next packet boundary
//   i_pkt_len  beats per packet (0 behaves as 1), sampled at packet start
//   i_rempty   FIFO empty flag
//   i_rdata    FIFO head word
//   o_rinc     FIFO pop strobe
//   o_tdata    stream data
//   o_tvalid   stream valid
//   o_tlast    final beat of a packet
//   i_tready   downstream ready
//   o_busy     FSM active or buffer holding data
//   o_pkt_cnt  packets completed downstream, wraps modulo 2^16
module fifo_rd_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [LEN_WIDTH-1:0]  i_pkt_len,
  input  logic                  i_rempty,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_rinc,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  output logic                  o_tlast,
  input  logic                  i_tready,
  output logic                  o_busy,
  output logic [15:0]           o_pkt_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]           state_reg, state_next;
  logic [1:0]           count_reg, count_next;
  logic                 wr_ptr_reg, rd_ptr_reg;
  logic [LEN_WIDTH-1:0] beat_reg, beat_next;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [15:0]          pkt_cnt_reg;

  logic                 push, pop;
  logic [LEN_WIDTH-1:0] len_eff;
  logic                 last_flag;
  logic [DATA_WIDTH:0]  head;

  // Pop only depends on registered state and the empty flag, so the FIFO
  // read port never sees a combinational path from downstream ready.
  assign push     = (state_reg != ST_IDLE) & ~i_rempty & (count_reg != 2'd2);
  assign pop      = o_tvalid & i_tready;
  assign o_rinc   = push;
  assign o_tvalid = (count_reg != 2'd0);

  // At beat 0 the live length is used (it is latched on this push);
  // mid-packet the latched length governs so later changes are ignored.
  assign len_eff   = (beat_reg != '0) ? len_reg :
                     ((i_pkt_len == '0) ? LEN_WIDTH'(1) : i_pkt_len);
  assign last_flag = (beat_reg == len_eff - LEN_WIDTH'(1));

  always_comb begin
    beat_next = beat_reg;
    if (push) begin
      beat_next = last_flag ? '0 : beat_reg + LEN_WIDTH'(1);
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // RUN decides between IDLE and STOP on the beat index after this edge's
  // push, so a word popped on the same edge is never left as a partial packet.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (i_en) state_next = ST_RUN;
      ST_RUN:  if (!i_en) state_next = (beat_next == '0) ? ST_IDLE : ST_STOP;
      ST_STOP: if (push && last_flag) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Two buffer entries, each a {last, data} register written at wr_ptr.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH:0] entry_reg;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= {last_flag, i_rdata};
        end
      end
    end
  endgenerate

  assign head      = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
  assign o_tdata   = o_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign o_tlast   = o_tvalid & head[DATA_WIDTH];
  assign o_busy    = (state_reg != ST_IDLE) | (count_reg != 2'd0);
  assign o_pkt_cnt = pkt_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      count_reg   <= 2'd0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      beat_reg    <= '0;
      len_reg     <= '0;
      pkt_cnt_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      beat_reg  <= beat_next;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
        if (beat_reg == '0) begin
          len_reg <= len_eff;
        end
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
        if (o_tlast) begin
          pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer
//   Drives fifo_rd_streamer from a queue acting as the FIFO and checks every
//   cycle against a packet-level reference model: a queue of expected
//   {last,data} beats plus a "beats remaining in packet" counter.
module tb_fifo_rd_streamer;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, en, rempty, rinc, tvalid, tlast, tready, busy;
  logic [LW-1:0] pkt_len;
  logic [DW-1:0] rdata, tdata;
  logic [15:0]   pkt_cnt;

  always #5 clk = ~clk;

  fifo_rd_streamer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_pkt_len(pkt_len),
    .i_rempty(rempty), .i_rdata(rdata), .o_rinc(rinc),
    .o_tdata(tdata), .o_tvalid(tvalid), .o_tlast(tlast),
    .i_tready(tready), .o_busy(busy), .o_pkt_cnt(pkt_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source FIFO contents and reference model.
  logic [DW-1:0] src[$];
  logic [DW:0]   outq[$];
  int            mode      = 0;   // 0 idle, 1 streaming, 2 finishing packet
  int            remaining = 0;   // beats still owed to the current packet
  logic [15:0]   cnt_m     = 16'd0;
  bit            verbose   = 1'b1;

  task automatic step();
    logic rinc_e, tvalid_e, dut_rinc;
    logic [DW-1:0] word;
    rempty = (src.size() == 0);
    rdata  = (src.size() != 0) ? src[0] : '0;
    #1;
    rinc_e   = (mode != 0) && (src.size() != 0) && (outq.size() < 2);
    tvalid_e = (outq.size() != 0);
    check_val("rinc", rinc, rinc_e);
    check_val("tvalid", tvalid, tvalid_e);
    if (tvalid_e) begin
      check_val("tdata", tdata, outq[0][DW-1:0]);
      check_val("tlast", tlast, outq[0][DW]);
    end
    check_val("busy", busy, (mode != 0) || tvalid_e);
    check_val("pkt_cnt", pkt_cnt, cnt_m);
    dut_rinc = rinc;
    if (rst) begin
      outq.delete();
      mode = 0; remaining = 0; cnt_m = 16'd0;
    end else begin
      if (tvalid_e && tready) begin
        if (verbose) $display("beat data=0x%02h last=%0d", outq[0][DW-1:0], outq[0][DW]);
        if (outq[0][DW]) cnt_m = cnt_m + 16'd1;
        void'(outq.pop_front());
      end
      if (rinc_e) begin
        word = src[0];
        if (remaining == 0) remaining = (pkt_len == 0) ? 1 : int'(pkt_len);
        remaining--;
        outq.push_back({remaining == 0, word});
      end
      case (mode)
        0: if (en) mode = 1;
        1: if (!en) mode = (remaining == 0) ? 0 : 2;
        2: if (rinc_e && remaining == 0) mode = 0;
        default: mode = 0;
      endcase
    end
    if (dut_rinc && src.size() != 0) void'(src.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) src.push_back(DW'(first + i));
  endtask

  initial begin
    logic [15:0] base;
    int k;
    rst = 1'b1; en = 1'b0; tready = 1'b0; pkt_len = '0; rempty = 1'b1; rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset / disabled: words waiting but nothing popped.
    load(8'hA0, 10); tready = 1'b1;
    run(5);
    check_val("rst_rinc", rinc, 0);
    check_val("rst_tvalid", tvalid, 0);
    check_val("rst_tdata", tdata, 0);
    check_val("rst_tlast", tlast, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_pkt_cnt", pkt_cnt, 0);
    check_val("rst_src_left", src.size(), 10);
    src.delete();

    // Streaming, 3 packets of 4.
    load(1, 12); pkt_len = 8'd4; en = 1'b1;
    run(16);
    check_val("stream_pkts", pkt_cnt, 3);
    check_val("stream_src_left", src.size(), 0);

    // Back-pressure in the middle of a stream.
    load(8'h10, 20);
    run(3);
    tready = 1'b0;
    run(5);
    check_val("bp_rinc_low", rinc, 0);
    tready = 1'b1;
    run(25);
    en = 1'b0;
    run(4);

    // Graceful stop after beat 2 of a 5-beat packet.
    src.delete(); load(1, 12); pkt_len = 8'd5; en = 1'b1;
    base = cnt_m;
    k = 0;
    while (remaining != 3 && k < 20) begin step(); k++; end
    check_val("stop_wait_timeout", k >= 20, 0);
    en = 1'b0;
    run(12);
    check_val("stop_src_left", src.size(), 7);
    check_val("stop_pkts", pkt_cnt, base + 16'd1);
    check_val("stop_busy", busy, 0);

    // Length changed 4 -> 2 mid-packet.
    src.delete(); load(8'h20, 12); pkt_len = 8'd4; en = 1'b1;
    base = cnt_m;
    k = 0;
    while (remaining != 2 && k < 20) begin step(); k++; end
    check_val("len_wait_timeout", k >= 20, 0);
    pkt_len = 8'd2;
    run(16);
    check_val("len_change_pkts", pkt_cnt, base + 16'd5);

    // Length 0 behaves as 1.
    load(8'h40, 6); pkt_len = 8'd0;
    base = cnt_m;
    run(10);
    check_val("len0_pkts", pkt_cnt, base + 16'd6);
    en = 1'b0;
    run(3);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) pkt_len = LW'($urandom_range(0, 5));
      tready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2) != 0 && src.size() < 8) src.push_back(DW'($urandom));
      step();
    end
    rst = 1'b0;

    // Reset mid-packet with two buffered words.
    rst = 1'b1; step(); rst = 1'b0;
    src.delete(); load(8'h60, 10); pkt_len = 8'd4; tready = 1'b0; en = 1'b1;
    k = 0;
    while (outq.size() != 2 && k < 10) begin step(); k++; end
    check_val("mid_rst_wait_timeout", k >= 10, 0);
    rst = 1'b1; step(); rst = 1'b0;
    check_val("mid_rst_tvalid", tvalid, 0);
    check_val("mid_rst_busy", busy, 0);
    tready = 1'b1;
    run(20);
    check_val("mid_rst_fresh_pkts", pkt_cnt, 2);
    en = 1'b0;
    run(3);

    // Counter wrap with single-beat packets.
    verbose = 1'b0;
    pkt_len = 8'd1; en = 1'b1; tready = 1'b1;
    k = 0;
    while (k < 70000) begin
      if (src.size() < 3) src.push_back(DW'($urandom));
      step();
      k++;
      if (cnt_m == 16'd0 && k > 4) break;
    end
    check_val("wrap_timeout", k >= 70000, 0);
    check_val("wrap_cnt", pkt_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
